// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: two requesters share one WIDTH-bit adder through a
// round-robin grant. The result sits in a single-entry output register until
// the consumer takes it. Drain and refill can happen in the same cycle.

// Per-requester handshake slice: ready when the slot is free and this lane won.
module adder_share_lane (
  input  logic valid,
  input  logic free,
  input  logic win,
  output logic ready,
  output logic fire
);
  // ready is gated by valid so an idle lane never advertises a grant
  always_comb begin
    ready = free & win & valid;
    fire  = ready;
  end
endmodule

module adder_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id,
  output logic [7:0]       txn_count
);
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic             id;
  } res_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  req_t [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] vld;
  logic [NUM_REQ-1:0] win;
  logic [NUM_REQ-1:0] rdy;
  logic [NUM_REQ-1:0] fire;

  state_t     state, state_nxt;
  res_t       res_q, res_nxt;
  logic       last_grant;
  logic       free;
  logic       winner;
  logic       accept;
  logic       drain;
  logic [WIDTH:0] sum_full;
  logic [WIDTH-1:0] op_a, op_b;

  // Bundle the flat requester ports into lane-indexed structs
  always_comb begin
    req[0] = '{valid: req0_valid, a: req0_a, b: req0_b};
    req[1] = '{valid: req1_valid, a: req1_a, b: req1_b};
    for (int n = 0; n < NUM_REQ; n++) vld[n] = req[n].valid;
  end

  // Round-robin pick: a lone requester wins; under contention the one not
  // granted last wins. The pointer only moves on accept, so idle cycles
  // leave priority where it was.
  always_comb begin
    free   = (state == EMPTY) | res_ready;
    winner = vld[1] & (~vld[0] | ~last_grant);
    win    = {winner, ~winner};
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      adder_share_lane u_lane (
        .valid (vld[gi]),
        .free  (free),
        .win   (win[gi]),
        .ready (rdy[gi]),
        .fire  (fire[gi])
      );
    end
  endgenerate

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  // Single shared adder fed by the winning lane's operands
  always_comb begin
    accept   = |fire;
    drain    = (state == FULL) & res_ready;
    op_a     = req[winner].a;
    op_b     = req[winner].b;
    sum_full = {1'b0, op_a} + {1'b0, op_b};
  end

  // Next state and next result; stale result fields hold on a plain drain
  always_comb begin
    state_nxt = state;
    res_nxt   = res_q;
    if (accept) begin
      state_nxt = FULL;
      res_nxt   = '{carry: sum_full[WIDTH], sum: sum_full[WIDTH-1:0], id: winner};
    end else if (drain) begin
      state_nxt = EMPTY;
    end
  end

  // State register; reset wins over any same-cycle accept or drain
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Result register, grant pointer and transaction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q      <= '0;
      last_grant <= 1'b1;
      txn_count  <= '0;
    end else begin
      res_q <= res_nxt;
      if (accept) begin
        last_grant <= winner;
        txn_count  <= txn_count + 8'd1;
      end
    end
  end

  assign res_valid = (state == FULL);
  assign res_sum   = res_q.sum;
  assign res_carry = res_q.carry;
  assign res_id    = res_q.id;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed table-driven bench for adder_share_arbiter plus a counter-wrap run.
module tb_adder_share_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       res_valid, res_ready, res_carry, res_id;
  logic [7:0] res_sum, txn_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_carry(res_carry), .res_id(res_id), .txn_count(txn_count)
  );

  typedef struct {
    logic       rst, v0;
    logic [7:0] a0, b0;
    logic       v1;
    logic [7:0] a1, b1;
    logic       rr;
    logic       e_r0, e_r1, e_vld;
    logic [7:0] e_sum;
    logic       e_c, e_id;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vt[20];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                              input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic rr,
                              input logic e_r0, input logic e_r1, input logic e_vld, input logic [7:0] e_sum,
                              input logic e_c, input logic e_id, input logic [7:0] e_cnt);
    vec_t v;
    v.rst = r; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.v1 = v1; v.a1 = a1; v.b1 = b1; v.rr = rr;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_vld = e_vld; v.e_sum = e_sum; v.e_c = e_c; v.e_id = e_id; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    //        rst v0 a0     b0     v1 a1     b1     rr  r0 r1 vld sum    c  id cnt
    vt[0]  = mk(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0, 8'd0);
    vt[1]  = mk(0, 1, 8'h10, 8'h20, 0, 8'h00, 8'h00, 1,  1, 0, 1, 8'h30, 0, 0, 8'd1);
    vt[2]  = mk(0, 0, 8'h00, 8'h00, 1, 8'hFF, 8'h02, 1,  0, 1, 1, 8'h01, 1, 1, 8'd2);
    vt[3]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1,  0, 0, 0, 8'h01, 1, 1, 8'd2);
    vt[4]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h01, 1, 1, 8'd2);
    // continuous contention, alternating grants starting with requester 0
    vt[5]  = mk(0, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 1,  1, 0, 1, 8'h03, 0, 0, 8'd3);
    vt[6]  = mk(0, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 1,  0, 1, 1, 8'h30, 0, 1, 8'd4);
    vt[7]  = mk(0, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 1,  1, 0, 1, 8'h03, 0, 0, 8'd5);
    vt[8]  = mk(0, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 1,  0, 1, 1, 8'h30, 0, 1, 8'd6);
    vt[9]  = mk(0, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 1,  1, 0, 1, 8'h03, 0, 0, 8'd7);
    vt[10] = mk(0, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 1,  0, 1, 1, 8'h30, 0, 1, 8'd8);
    // backpressure: slot full, nothing granted, result stable
    vt[11] = mk(0, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 0,  0, 0, 1, 8'h30, 0, 1, 8'd8);
    vt[12] = mk(0, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 0,  0, 0, 1, 8'h30, 0, 1, 8'd8);
    vt[13] = mk(0, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 0,  0, 0, 1, 8'h30, 0, 1, 8'd8);
    // consumer returns: drain and refill in the same cycle
    vt[14] = mk(0, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 1,  1, 0, 1, 8'h03, 0, 0, 8'd9);
    // reset with a held result and req0 valid
    vt[15] = mk(1, 1, 8'h01, 8'h02, 0, 8'h00, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0, 8'd0);
    vt[16] = mk(0, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 0,  1, 0, 1, 8'h03, 0, 0, 8'd1);
    vt[17] = mk(0, 1, 8'h01, 8'h02, 1, 8'h80, 8'h80, 1,  0, 1, 1, 8'h00, 1, 1, 8'd2);
    vt[18] = mk(0, 0, 8'h00, 8'h00, 1, 8'hFF, 8'hFF, 1,  0, 1, 1, 8'hFE, 1, 1, 8'd3);
    vt[19] = mk(0, 1, 8'h01, 8'h02, 1, 8'h10, 8'h20, 1,  1, 0, 1, 8'h03, 0, 0, 8'd4);

    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    #1;

    for (int i = 0; i < 20; i++) begin
      rst = vt[i].rst; res_ready = vt[i].rr;
      req0_valid = vt[i].v0; req0_a = vt[i].a0; req0_b = vt[i].b0;
      req1_valid = vt[i].v1; req1_a = vt[i].a1; req1_b = vt[i].b1;
      #2;
      check("req0_ready", i, 32'(req0_ready), 32'(vt[i].e_r0));
      check("req1_ready", i, 32'(req1_ready), 32'(vt[i].e_r1));
      @(posedge clk); #1;
      check("res_valid", i, 32'(res_valid), 32'(vt[i].e_vld));
      check("res_sum",   i, 32'(res_sum),   32'(vt[i].e_sum));
      check("res_carry", i, 32'(res_carry), 32'(vt[i].e_c));
      check("res_id",    i, 32'(res_id),    32'(vt[i].e_id));
      check("txn_count", i, 32'(txn_count), 32'(vt[i].e_cnt));
    end

    // Counter wrap: fresh reset, then 256 single-requester accepts
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("wrap_reset_cnt", 0, 32'(txn_count), 32'd0);
    for (int i = 0; i < 256; i++) begin
      req0_valid = 1'b1; req0_a = 8'(i); req0_b = 8'd3;
      #2;
      if (i == 0 || i == 255) check("wrap_ready", i, 32'(req0_ready), 32'd1);
      @(posedge clk); #1;
      if (i == 254) check("wrap_cnt_255", i, 32'(txn_count), 32'd255);
      if (i == 253) check("wrap_sum", i, 32'({res_carry, res_sum}), 32'd256);
    end
    req0_valid = 1'b0;
    check("wrap_cnt_0", 256, 32'(txn_count), 32'd0);
    check("wrap_last_sum", 256, 32'({res_carry, res_sum}), 32'd258);
    @(posedge clk); #1;
    check("idle_drain_vld", 0, 32'(res_valid), 32'd0);
    check("idle_cnt", 0, 32'(txn_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Mutual exclusion of the two readys, checked every cycle
  always @(negedge clk) begin
    if (req0_ready && req1_ready) begin
      fails++;
      $display("FAIL both_ready: got req0_ready=1 req1_ready=1, expected at most one");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter that shares one WIDTH-bit adder between two requesters. Each requester presents an operand pair through a valid/ready handshake. The block grants one pair per cycle, adds it, and holds the sum, carry and requester ID in a single-entry output register until the consumer accepts it. It sits between the input-capture logic and the output-pin muxing of the top-level tile.

## Interface
- WIDTH, 8, operand and sum width
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-high
- req0_valid  input  1  requester 0 has an operand pair
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req0_ready  output  1  requester 0 pair accepted this cycle (when req0_valid=1)
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1
- res_valid  output  1  result register holds an unconsumed result
- res_ready  input  1  consumer accepts result this cycle
- res_sum  output  WIDTH  (a+b) mod 2^WIDTH
- res_carry  output  1  carry-out of a+b
- res_id  output  1  index of the requester that produced the result
- txn_count  output  8  number of accepted pairs, wraps 255->0

## Operation
- Slot free: free = !res_valid | res_ready. Same-cycle drain and refill is allowed, so throughput is 1 pair/cycle.
- Grant (combinational):
  - only one valid requester: that requester wins;
  - both valid: the requester not granted last wins;
  - neither valid: no grant.
- reqN_ready = free & (winner == N). Both readys are never 1 in the same cycle.
- reqN_ready may depend combinationally on reqN_valid, req(1-N)_valid, res_valid and res_ready.
- Accept = reqN_valid & reqN_ready. On accept, at the next edge:
  - {res_carry, res_sum} <= a + b, computed at WIDTH+1 bits;
  - res_id <= N; res_valid <= 1;
  - last-grant pointer <= N; txn_count <= txn_count + 1.
- Drain without refill (res_valid & res_ready, no accept): res_valid <= 0. res_sum, res_carry and res_id keep their stale values.
- No accept and no drain: result register and pointer hold.
- Pointer changes only on accept. An idle cycle does not rotate priority.
- Requesters must hold a, b and valid stable until accepted. The block does not require this for correctness; it samples only on accept.
- State machine (res_valid is the state bit):
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with accept, or when not drained.
  - EMPTY -> EMPTY otherwise.

## Timing
- Reset values (next edge with rst=1):
  - res_valid=0, res_sum=0, res_carry=0, res_id=0, txn_count=0;
  - last-grant pointer=1, so requester 0 wins the first contention.
- Combinational outputs after reset: req0_ready=1 if req0_valid, else req1_ready=1 if req1_valid.
- Reset mid-operation discards any held result with no handshake. rst has priority over accept and drain in the same cycle.
- Latency: accept at edge k gives res_valid=1 and the result visible after edge k; earliest consumption is in cycle k+1.
- Backpressure: while res_valid=1 and res_ready=0, both readys are 0.
- Fairness: under continuous contention with res_ready=1, grants alternate 0,1,0,1. Each requester waits at most 1 accepted transaction.
- Width rule: the carry is bit WIDTH of the zero-extended sum. There is no saturation.

## Test plan
- Reset, then req0 only with a=0x10, b=0x20, res_ready=1 -> req0_ready=1 in cycle 0; next cycle res_valid=1, res_sum=0x30, res_carry=0, res_id=0, txn_count=1.
- Overflow: req1 with a=0xFF, b=0x02 -> res_sum=0x01, res_carry=1, res_id=1.
- Both requesters valid continuously for 6 cycles, res_ready=1 -> res_id sequence 0,1,0,1,0,1; 1 result per cycle; txn_count=6.
- res_ready=0 for 3 cycles with both requesters valid -> res_valid stays 1 and res_sum is stable; both readys=0. When res_ready rises, a new accept happens in the same cycle with no bubble.
- rst asserted while res_valid=1 and req0 valid -> next cycle res_valid=0, txn_count=0, no accept recorded. On the next contention requester 0 wins.
- 256 accepted transactions -> txn_count wraps to 0.
